long_multi_rf: RTL and testbench
================================

Name: long_multi_rf

Overview:
- Parametrised multi-port register file; next generation of the single-port, block-RAM-style register file used in the long_* synthesis test set.
- Generalises width, depth and port count.
- Adds per-port read enables, deterministic write priority, write-to-read bypass on every read port, out-of-range address handling, and a post-reset sequential clear engine with a busy flag.

Parameters:
- WIDTH, 13, data width in bits
- DEPTH, 16, number of entries (any value >= 2; need not be a power of two)
- AW, 7, address width per port (must satisfy 2**AW >= DEPTH)
- NW, 2, number of write ports
- NR, 2, number of read ports

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- we  in  NW  write enable per write port
- waddr  in  NW*AW  packed write addresses, port j at [j*AW +: AW]
- din  in  NW*WIDTH  packed write data, port j at [j*WIDTH +: WIDTH]
- re  in  NR  read enable per read port
- raddr  in  NR*AW  packed read addresses, port i at [i*AW +: AW]
- q  out  NR*WIDTH  packed registered read data, port i at [i*WIDTH +: WIDTH]
- busy  out  1  high while the clear engine is running

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled only at the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - q <= 0 on all ports; busy <= 1; state <= INIT; clear pointer <= 0.
  - Array contents are not modified during that edge.
- State INIT:
  - At each edge with rst_n=1, write entry[ptr] <= 0 and ptr <= ptr+1.
  - The edge that clears entry DEPTH-1 moves the state to READY and sets busy <= 0.
  - busy is therefore high for exactly DEPTH edges after reset release.
  - All we inputs are ignored.
  - Every read port with re=1 loads q_i <= 0; ports with re=0 hold.
- State READY, writes:
  - At an edge, each port j with we[j]=1 and waddr_j < DEPTH writes din_j.
  - If waddr_j >= DEPTH, the write is dropped silently.
  - Same address written by several ports in one cycle: the highest port index wins.
- State READY, reads (1-cycle latency):
  - re[i]=0: q_i holds its value.
  - re[i]=1 and raddr_i >= DEPTH: q_i <= 0.
  - re[i]=1 and any in-range write this cycle targets raddr_i: q_i <= din of the highest-index such port (write-through bypass).
  - Otherwise q_i <= entry[raddr_i] (pre-edge contents).
- Read ports are fully independent. Any number of them may read the same address in the same cycle.
- Reset mid-INIT or mid-READY: returns to INIT and clears the whole array again from entry 0. No write issued in the reset cycle takes effect.
- No combinational path from inputs to q or busy; both are registers.
- Storage must stay inferable as RAM: no reset on the array other than the clear engine.

Test Plan:
- Clear sequence: assert rst_n=0 for 2 cycles, release -> busy=1 for exactly 16 edges, then 0. Reads of addresses 0..15 then return 0. we=1 during INIT leaves the array unchanged.
- Basic write then read: write port 0 writes addr 5 with 0x1ABC. Next cycle read port 1 reads addr 5 -> q1=0x1ABC one edge later. re1=0 on the following cycle -> q1 holds 0x1ABC.
- Bypass and priority: in the same cycle port 0 writes 0x0111 and port 1 writes 0x0222 to addr 3, while read port 0 reads addr 3 -> q0=0x0222. A later read of addr 3 -> 0x0222.
- Out-of-range: write addr 20 with 0x1FFF, then read addr 4 -> unchanged value. Read addr 100 -> q=0. Read addr 15 -> valid data (wrap boundary).
- Reset mid-operation: fill addr 0..15 with nonzero data, pulse rst_n=0 for one edge -> q=0, busy=1 for 16 edges, and all entries read 0 afterwards.
- Concurrent ports: both read ports read distinct addresses while both write ports write other addresses -> each q returns the pre-write contents of its own address, with no cross-port interference.

Source files
------------

// File: rtl/long_multi_rf.sv
// ---------------------------------------------------------------------------
// long_multi_rf
//   Parametrised multi-port register file with a sequential clear engine.
//   - NW write ports: the highest port index wins on a same-address write.
//   - NR read ports: 1-cycle registered read, with write-through bypass.
//   - Any address >= DEPTH reads as 0, and a write to it is dropped.
//   - After reset the clear engine zeroes one entry per edge and holds busy
//     high. While it runs, writes are ignored and enabled reads return 0.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   we     in   [NW]        write enable per write port
//   waddr  in   [NW*AW]     write address, port j at [j*AW +: AW]
//   din    in   [NW*WIDTH]  write data, port j at [j*WIDTH +: WIDTH]
//   re     in   [NR]        read enable per read port
//   raddr  in   [NR*AW]     read address, port i at [i*AW +: AW]
//   q      out  [NR*WIDTH]  registered read data, port i at [i*WIDTH +: WIDTH]
//   busy   out  high while the clear engine is running (state == INIT)
//
// Handshake: there is none. Writes and reads are accepted on every edge
// where the matching enable is high. The exception is INIT (busy=1): then
// writes are dropped and enabled reads load 0.
// ---------------------------------------------------------------------------
module long_multi_rf #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int AW    = 7,
    parameter int NW    = 2,
    parameter int NR    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*WIDTH-1:0] din,
    input  logic [NR-1:0]       re,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*WIDTH-1:0] q,
    output logic                busy
);

    localparam int             IW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [NR*WIDTH-1:0] q_q, q_d;

    // Storage: no reset, so that it stays inferable as RAM.
    logic [WIDTH-1:0]    mem_q [DEPTH];

    // Write ports that actually land this cycle, plus their narrowed index.
    logic [NW-1:0]       wv;
    logic [IW-1:0]       widx [NW];
    logic [WIDTH-1:0]    rd_val;

    always_comb begin
        for (int j = 0; j < NW; j++) begin
            widx[j] = waddr[j*AW +: IW];
            wv[j]   = (state_q == ST_READY) && we[j] &&
                      ({1'b0, waddr[j*AW +: AW]} < DEPTH_W);
        end
    end

    // Array update. Either the clear engine writes one zero, or the write
    // ports do. A later loop iteration overrides an earlier one, which gives
    // the highest port index priority on a shared address.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                mem_q[ptr_q[IW-1:0]] <= '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wv[j]) begin
                        mem_q[widx[j]] <= din[j*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Read data. An in-range write to the same address is forwarded, and
    // again the highest write port wins. This matches what the array will
    // hold after the edge.
    always_comb begin
        q_d    = q_q;
        rd_val = '0;
        for (int i = 0; i < NR; i++) begin
            if (re[i]) begin
                rd_val = '0;
                if ((state_q == ST_READY) &&
                    ({1'b0, raddr[i*AW +: AW]} < DEPTH_W)) begin
                    rd_val = mem_q[raddr[i*AW +: IW]];
                    for (int j = 0; j < NW; j++) begin
                        if (wv[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                            rd_val = din[j*WIDTH +: WIDTH];
                        end
                    end
                end
                q_d[i*WIDTH +: WIDTH] = rd_val;
            end
        end
    end

    // Clear engine: it walks ptr from 0 to DEPTH-1, then moves to READY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == LAST) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
        end
    end

    // busy is the registered state itself, so it also serves as the FSM view.
    assign busy = (state_q == ST_INIT);
    assign q    = q_q;

endmodule

// File: tb/tb_long_multi_rf.sv
// ---------------------------------------------------------------------------
// tb_long_multi_rf
//   Directed bench for long_multi_rf with its default parameters.
//   A reference model predicts q and busy. Every negedge after the first
//   reset compares the DUT against that model. Literal expectations at key
//   points pin the model itself.
// ---------------------------------------------------------------------------
module tb_long_multi_rf;

    localparam int W  = 13;
    localparam int D  = 16;
    localparam int A  = 7;
    localparam int NW = 2;
    localparam int NR = 2;

    logic              clk;
    logic              rst_n;
    logic [NW-1:0]     we;
    logic [NW*A-1:0]   waddr;
    logic [NW*W-1:0]   din;
    logic [NR-1:0]     re;
    logic [NR*A-1:0]   raddr;
    logic [NR*W-1:0]   q;
    logic              busy;

    int checks = 0;
    int passes = 0;

    long_multi_rf #(.WIDTH(W), .DEPTH(D), .AW(A), .NW(NW), .NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .din   (din),
        .re    (re),
        .raddr (raddr),
        .q     (q),
        .busy  (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Reads see the array as it stands after this edge's writes. That gives
    // both the bypass and the highest-port-wins rule directly.
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_q   [NR];
    int           m_busy_left = 0;
    bit           m_known     = 1'b0;

    task automatic model_step();
        logic [W-1:0] nxt [D];
        int a;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_q[i] = '0;
            m_busy_left = D;
            m_known     = 1'b1;
        end else if (m_known) begin
            if (m_busy_left > 0) begin
                for (int i = 0; i < NR; i++) if (re[i]) m_q[i] = '0;
                m_mem[D - m_busy_left] = '0;
                m_busy_left--;
            end else begin
                nxt = m_mem;
                for (int j = 0; j < NW; j++) begin
                    a = int'(waddr[j*A +: A]);
                    if (we[j] && a < D) nxt[a] = din[j*W +: W];
                end
                for (int i = 0; i < NR; i++) begin
                    if (re[i]) begin
                        a = int'(raddr[i*A +: A]);
                        m_q[i] = (a < D) ? nxt[a] : '0;
                    end
                end
                m_mem = nxt;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    initial forever begin
        @(negedge clk);
        if (m_known) begin
            check("model_q0",   q[0 +: W], m_q[0]);
            check("model_q1",   q[W +: W], m_q[1]);
            check("model_busy", W'(busy),  W'(m_busy_left > 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we = '0; re = '0; waddr = '0; raddr = '0; din = '0;
    endtask

    task automatic set_w(input int j, input int addr, input logic [W-1:0] data);
        we[j]           = 1'b1;
        waddr[j*A +: A] = A'(addr);
        din[j*W +: W]   = data;
    endtask

    task automatic set_r(input int i, input int addr);
        re[i]           = 1'b1;
        raddr[i*A +: A] = A'(addr);
    endtask

    // Counts edges while busy is high. The count is bounded so that a stuck
    // busy still reaches the summary.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, W'(n), W'(D));
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < D; a += 2) begin
            idle();
            set_r(0, a);
            set_r(1, a + 1);
            tick();
            check(name, q[0 +: W], '0);
            check(name, q[W +: W], '0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_q0", q[0 +: W], '0);
        check("rst_q1", q[W +: W], '0);
        check("rst_busy", W'(busy), W'(1));

        // Clear sequence. Writes to entry 0 are held high and must be ignored.
        rst_n = 1'b1;
        set_w(0, 0, 13'h1555);
        set_r(0, 0);
        set_r(1, 1);
        count_busy("init_busy_edges");
        check("init_read_q0", q[0 +: W], '0);
        read_all_zero("init_cleared");

        // Basic write, then read and hold.
        idle(); set_w(0, 5, 13'h1ABC); tick();
        idle(); set_r(1, 5); tick();
        check("basic_read", q[W +: W], 13'h1ABC);
        idle(); tick();
        check("basic_hold", q[W +: W], 13'h1ABC);

        // Bypass with write priority.
        idle(); set_w(0, 3, 13'h0111); set_w(1, 3, 13'h0222); set_r(0, 3); tick();
        check("bypass_prio", q[0 +: W], 13'h0222);
        idle(); set_r(0, 3); tick();
        check("prio_stored", q[0 +: W], 13'h0222);

        // Out-of-range handling.
        idle(); set_w(0, 4, 13'h0AAA); tick();
        idle(); set_w(0, 20, 13'h1FFF); tick();
        idle(); set_r(0, 4); tick();
        check("oor_write_dropped", q[0 +: W], 13'h0AAA);
        idle(); set_r(1, 100); tick();
        check("oor_read_zero", q[W +: W], '0);
        idle(); set_w(1, 15, 13'h0F0F); tick();
        idle(); set_r(1, 15); tick();
        check("last_entry", q[W +: W], 13'h0F0F);

        // Concurrent ports with no shared addresses.
        idle(); set_w(0, 7, 13'h0777); set_w(1, 8, 13'h0888); tick();
        idle(); set_r(0, 7); set_r(1, 8);
        set_w(0, 9, 13'h1999); set_w(1, 10, 13'h1AAA); tick();
        check("conc_q0", q[0 +: W], 13'h0777);
        check("conc_q1", q[W +: W], 13'h0888);
        idle(); set_r(0, 9); set_r(1, 10); tick();
        check("conc_w0", q[0 +: W], 13'h1999);
        check("conc_w1", q[W +: W], 13'h1AAA);

        // Reset in mid-operation.
        for (int a = 0; a < D; a += 2) begin
            idle();
            set_w(0, a,     W'(13'h1000 | (a * 13'h011)));
            set_w(1, a + 1, W'(13'h1000 | ((a + 1) * 13'h011)));
            tick();
        end
        idle(); set_r(0, 6); tick();
        check("fill_read", q[0 +: W], 13'h1066);
        idle(); set_r(0, 6); set_w(0, 6, 13'h1234); rst_n = 1'b0; tick();
        check("midrst_q0", q[0 +: W], '0);
        check("midrst_busy", W'(busy), W'(1));
        rst_n = 1'b1;
        idle();
        count_busy("midrst_busy_edges");
        read_all_zero("midrst_cleared");

        idle(); tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
